ac_inv_reciprocal: RTL and testbench
====================================

AC_INV_RECIPROCAL -- requirements
Module: ac_inv_reciprocal

Interface
REQ-001 Parameter OMEGA, default 61440, haze-retention factor ω in Q0.16 (0.9375); legal range 1..65535.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; asserted (0) clears all state immediately, independent of clk.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 Ac_R, Ac_G, Ac_B  input  8 each  atmospheric light per channel, unsigned integer.
REQ-006 Ac_Inv_R, Ac_Inv_G, Ac_Inv_B  output  16 each  ω/Ac per channel in Q0.16, registered; feeds the transmission-estimation multiplier Ac_Inv port.
REQ-007 busy  output  1  high while a computation is in progress.
REQ-008 done  output  1  single-cycle pulse when new Ac_Inv values become valid.

Function
REQ-009 Each result SHALL equal floor(OMEGA / Ac_c), c in {R,G,B}, truncated, exact to 1 LSB of Q0.16.
REQ-010 Ac_c = 0 SHALL be treated as Ac_c = 1 (result = OMEGA); no divide-by-zero state or X.
REQ-011 Division SHALL be a sequential restoring (shift-subtract) divider: 16 iterations per channel, one quotient bit per clk, MSB first; one shared divider datapath, channels processed R, then G, then B.
REQ-012 States: IDLE, DIV, DONE.
REQ-013 IDLE: busy=0; start=1 at a rising edge captures Ac_R/G/B into internal registers, loads channel R, moves to DIV.
REQ-014 DIV: busy=1; 48 iteration cycles total; on the 16th iteration of a channel its quotient goes to an internal result register and the next channel loads in the same cycle.
REQ-015 After the 48th iteration, state SHALL go to DONE; in DONE all three Ac_Inv outputs update simultaneously from the internal results, done=1 for exactly one cycle, busy=1, then IDLE.
REQ-016 Latency: done high in the cycle beginning at the 49th rising edge after the edge that sampled start; a new start may be sampled on the edge ending the done cycle at earliest (IDLE), i.e. one result per 50 cycles max.
REQ-017 start while busy=1 SHALL be ignored (not queued); input changes after capture SHALL NOT affect the running computation.
REQ-018 Ac_Inv outputs SHALL hold their last values between done pulses; never partially updated (no mixed-channel glitch seen by downstream multiplier).
REQ-019 Internal remainder width 9 bits, dividend shift register 16 bits; no overflow possible for 8-bit divisor >= 1.

Reset
REQ-020 rst=0 SHALL force: state IDLE, busy=0, done=0, Ac_Inv_R/G/B=0, all internal registers 0, asynchronously.
REQ-021 rst asserted mid-DIV or in DONE SHALL abort the computation; no done pulse SHALL follow release.
REQ-022 After rst deasserts, the first start SHALL be sampled no earlier than the first rising edge at which rst=1.

Verification
REQ-023 Basic: OMEGA=61440, Ac=(255,128,200), pulse start -> done after 49 edges, Ac_Inv=(240,480,307), busy high 49 cycles.
REQ-024 Boundaries: Ac=(1,0,255) -> (61440,61440,240); OMEGA=65535, Ac=(1,2,3) -> (65535,32767,21845).
REQ-025 Busy lockout: start held high continuously with Ac changing every cycle -> results match Ac captured at first sample only; back-to-back results every 50 cycles.
REQ-026 Reset mid-op: assert rst at cycle 20 of DIV -> outputs 0, busy 0 immediately; release, no done pulse; new start then gives correct results.
REQ-027 Hold: after done, change Ac inputs without start for 100 cycles -> Ac_Inv unchanged, done stays 0.
REQ-028 Random: 10k random Ac triples and OMEGA values vs. floor(OMEGA/max(Ac,1)) reference model, zero mismatches.

Source files
------------

// File: rtl/ac_inv_reciprocal.sv
// Reciprocal of atmospheric light: Ac_Inv_c = floor(OMEGA / max(Ac_c,1)) in Q0.16 for R, G and B,
// computed by one shared 16-step restoring divider and published to all three outputs at once.
module ac_inv_reciprocal #(
  parameter int unsigned OMEGA = 61440
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  Ac_R,
  input  logic [7:0]  Ac_G,
  input  logic [7:0]  Ac_B,
  output logic [15:0] Ac_Inv_R,
  output logic [15:0] Ac_Inv_G,
  output logic [15:0] Ac_Inv_B,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    CH_R,
    CH_G,
    CH_B
  } chan_t;

  localparam logic [15:0] OMEGA_Q = 16'(OMEGA);

  state_t      r_state;
  state_t      w_next_state;
  chan_t       r_ch;
  logic [3:0]  r_bit;
  logic [7:0]  r_ac_r, r_ac_g, r_ac_b;
  logic [7:0]  r_dvs;
  logic [8:0]  r_rem;
  logic [15:0] r_dvd;
  logic [15:0] r_q_r, r_q_g, r_q_b;
  logic [15:0] r_inv_r, r_inv_g, r_inv_b;
  logic        r_done;

  logic [8:0]  w_shift;
  logic [9:0]  w_diff;
  logic        w_qbit;
  logic [8:0]  w_rem_next;
  logic [15:0] w_quot;
  logic        w_last_iter;

  // A zero divisor is replaced by one so the quotient saturates at OMEGA.
  function automatic logic [7:0] nz(input logic [7:0] v);
    return (v == 8'd0) ? 8'd1 : v;
  endfunction

  // Remainder stays below the divisor, so the shifted value always fits in 9 bits.
  assign w_shift     = {r_rem[7:0], r_dvd[15]};
  assign w_diff      = {1'b0, w_shift} - {2'b00, r_dvs};
  assign w_qbit      = ~w_diff[9];
  assign w_rem_next  = w_qbit ? w_diff[8:0] : w_shift;
  assign w_quot      = {r_dvd[14:0], w_qbit};
  assign w_last_iter = (r_bit == 4'd15);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next_state = S_DIV;
      S_DIV:  if (w_last_iter && (r_ch == CH_B)) w_next_state = S_DONE;
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ch    <= CH_R;
      r_bit   <= 4'd0;
      r_ac_r  <= 8'd0;
      r_ac_g  <= 8'd0;
      r_ac_b  <= 8'd0;
      r_dvs   <= 8'd0;
      r_rem   <= 9'd0;
      r_dvd   <= 16'd0;
      r_q_r   <= 16'd0;
      r_q_g   <= 16'd0;
      r_q_b   <= 16'd0;
      r_inv_r <= 16'd0;
      r_inv_g <= 16'd0;
      r_inv_b <= 16'd0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ac_r <= nz(Ac_R);
            r_ac_g <= nz(Ac_G);
            r_ac_b <= nz(Ac_B);
            r_dvs  <= nz(Ac_R);
            r_dvd  <= OMEGA_Q;
            r_rem  <= 9'd0;
            r_bit  <= 4'd0;
            r_ch   <= CH_R;
          end
        end
        S_DIV: begin
          r_bit <= r_bit + 4'd1;
          r_rem <= w_rem_next;
          r_dvd <= w_quot;
          if (w_last_iter) begin
            // Retire this channel's quotient and load the next divisor in the same cycle.
            unique case (r_ch)
              CH_R: begin
                r_q_r <= w_quot;
                r_ch  <= CH_G;
                r_dvs <= r_ac_g;
                r_dvd <= OMEGA_Q;
                r_rem <= 9'd0;
              end
              CH_G: begin
                r_q_g <= w_quot;
                r_ch  <= CH_B;
                r_dvs <= r_ac_b;
                r_dvd <= OMEGA_Q;
                r_rem <= 9'd0;
              end
              default: begin
                r_q_b <= w_quot;
              end
            endcase
          end
        end
        S_DONE: begin
          r_inv_r <= r_q_r;
          r_inv_g <= r_q_g;
          r_inv_b <= r_q_b;
          r_done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign Ac_Inv_R = r_inv_r;
  assign Ac_Inv_G = r_inv_g;
  assign Ac_Inv_B = r_inv_b;

endmodule

// File: tb/tb_ac_inv_reciprocal.sv
// Directed bench for ac_inv_reciprocal: three instances (OMEGA = 61440, 65535, 1) share the stimulus,
// each checked against floor(OMEGA / max(Ac,1)) plus hand-computed constants.
module tb_ac_inv_reciprocal;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  ac_r, ac_g, ac_b;
  logic [15:0] inv_r [3];
  logic [15:0] inv_g [3];
  logic [15:0] inv_b [3];
  logic        busy  [3];
  logic        done  [3];

  int n_assert;
  int n_fail;

  localparam int unsigned OM0 = 61440;
  localparam int unsigned OM1 = 65535;
  localparam int unsigned OM2 = 1;

  ac_inv_reciprocal #(.OMEGA(OM0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .Ac_R(ac_r), .Ac_G(ac_g), .Ac_B(ac_b),
    .Ac_Inv_R(inv_r[0]), .Ac_Inv_G(inv_g[0]), .Ac_Inv_B(inv_b[0]), .busy(busy[0]), .done(done[0])
  );
  ac_inv_reciprocal #(.OMEGA(OM1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .Ac_R(ac_r), .Ac_G(ac_g), .Ac_B(ac_b),
    .Ac_Inv_R(inv_r[1]), .Ac_Inv_G(inv_g[1]), .Ac_Inv_B(inv_b[1]), .busy(busy[1]), .done(done[1])
  );
  ac_inv_reciprocal #(.OMEGA(OM2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .Ac_R(ac_r), .Ac_G(ac_g), .Ac_B(ac_b),
    .Ac_Inv_R(inv_r[2]), .Ac_Inv_G(inv_g[2]), .Ac_Inv_B(inv_b[2]), .busy(busy[2]), .done(done[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint ref_q(input longint om, input logic [7:0] ac);
    return om / ((ac == 8'd0) ? 1 : longint'(ac));
  endfunction

  function automatic longint omega_of(input int i);
    return (i == 0) ? OM0 : (i == 1) ? OM1 : OM2;
  endfunction

  task automatic check_all(input string tag, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s dut%0d R", tag, i), inv_r[i], ref_q(omega_of(i), r));
      check($sformatf("%s dut%0d G", tag, i), inv_g[i], ref_q(omega_of(i), g));
      check($sformatf("%s dut%0d B", tag, i), inv_b[i], ref_q(omega_of(i), b));
    end
  endtask

  // One transaction: pulse start, scramble inputs after capture, measure latency and busy length.
  task automatic run_op(input string tag, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int  edges;
    int  busy_cyc;
    bit  got;
    @(negedge clk);
    ac_r = r; ac_g = g; ac_b = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ac_r = 8'($urandom); ac_g = 8'($urandom); ac_b = 8'($urandom);
    busy_cyc = busy[0] ? 1 : 0;
    edges = 0;
    got = 1'b0;
    for (int k = 1; k <= 100 && !got; k++) begin
      @(posedge clk);
      #1;
      edges = k;
      if (done[0]) got = 1'b1;
      else if (busy[0]) busy_cyc++;
    end
    check({tag, " latency"}, edges, 49);
    check({tag, " busy cycles"}, busy_cyc, 49);
    check({tag, " done all"}, {done[0], done[1], done[2]}, 3'b111);
    check_all(tag, r, g, b);
    @(posedge clk);
    #1;
    check({tag, " done width"}, done[0], 0);
  endtask

  initial begin
    logic [7:0] cap_r, cap_g, cap_b, nr, ng, nb;
    logic [15:0] hold_r, hold_g, hold_b;
    int n_done, last_done, bad, saw_done;
    bit got;
    n_assert = 0;
    n_fail   = 0;
    rst   = 1'b0;
    start = 1'b0;
    ac_r  = 8'd0; ac_g = 8'd0; ac_b = 8'd0;

    // Reset state, with start held high to confirm it is ignored during reset.
    #12;
    start = 1'b1;
    #20;
    check("reset busy", busy[0], 0);
    check("reset done", done[0], 0);
    check("reset inv", {inv_r[0], inv_g[0], inv_b[0]}, 48'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post reset idle", busy[0], 0);

    // Basic vector with hand values: 61440/(255,128,200) and 65535/(255,128,200).
    run_op("basic", 8'd255, 8'd128, 8'd200);
    check("basic hand R", inv_r[0], 240);
    check("basic hand G", inv_g[0], 480);
    check("basic hand B", inv_b[0], 307);
    check("basic hand om1", {inv_r[1], inv_g[1], inv_b[1]}, {16'd257, 16'd511, 16'd327});

    // Boundaries: divisor 1, zero treated as 1, divisor 255; OMEGA=65535 and OMEGA=1 extremes.
    run_op("bound1", 8'd1, 8'd0, 8'd255);
    check("bound1 hand", {inv_r[0], inv_g[0], inv_b[0]}, {16'd61440, 16'd61440, 16'd240});
    check("bound1 om2", {inv_r[2], inv_g[2], inv_b[2]}, {16'd1, 16'd1, 16'd0});
    run_op("bound2", 8'd1, 8'd2, 8'd3);
    check("bound2 hand", {inv_r[1], inv_g[1], inv_b[1]}, {16'd65535, 16'd32767, 16'd21845});
    run_op("zeros", 8'd0, 8'd0, 8'd0);

    // Hold: inputs wander without start; outputs and done must stay put.
    hold_r = inv_r[0]; hold_g = inv_g[0]; hold_b = inv_b[0];
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      ac_r = 8'($urandom); ac_g = 8'($urandom); ac_b = 8'($urandom);
      if (done[0] || busy[0] || inv_r[0] !== hold_r || inv_g[0] !== hold_g || inv_b[0] !== hold_b) bad++;
    end
    check("hold disturbances", bad, 0);

    // Busy lockout: start held high, inputs change every cycle; each capture is the value at the sampling edge.
    cap_r = 8'd0; cap_g = 8'd0; cap_b = 8'd0;
    n_done = 0; last_done = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      start = 1'b1;
      nr = 8'($urandom); ng = 8'($urandom); nb = 8'($urandom);
      ac_r = nr; ac_g = ng; ac_b = nb;
      if (!busy[0]) begin
        cap_r = nr; cap_g = ng; cap_b = nb;
      end
      @(posedge clk);
      #1;
      if (done[0]) begin
        n_done++;
        check_all($sformatf("lockout#%0d", n_done), cap_r, cap_g, cap_b);
        check($sformatf("lockout#%0d edge", n_done), k, (last_done < 0) ? 49 : last_done + 50);
        last_done = k;
      end
    end
    check("lockout done count", n_done, 4);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("lockout idle", busy[0], 0);

    // Reset in the middle of a division: immediate clear, no done afterwards.
    @(negedge clk);
    ac_r = 8'd7; ac_g = 8'd9; ac_b = 8'd11; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midreset busy", busy[0], 0);
    check("midreset done", done[0], 0);
    check("midreset inv", {inv_r[0], inv_g[0], inv_b[0]}, 48'd0);
    @(negedge clk);
    rst = 1'b1;
    saw_done = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk);
      #1;
      if (done[0] || busy[0]) saw_done++;
    end
    check("midreset no done", saw_done, 0);
    run_op("after reset", 8'd7, 8'd9, 8'd11);

    // Random triples with zeros mixed in.
    for (int n = 0; n < 30; n++) begin
      nr = (n % 7 == 0) ? 8'd0 : 8'($urandom);
      ng = 8'($urandom);
      nb = (n % 5 == 0) ? 8'd1 : 8'($urandom);
      run_op($sformatf("rand%0d", n), nr, ng, nb);
    end

    // Sanity bound: nothing should be pending now.
    got = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (done[0]) got = 1'b1;
    end
    check("final quiet", got, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
